display_decoder: RTL and testbench



---
 rtl/display_decoder_if.sv | 42 ++++
 rtl/display_decoder.sv | 133 +++++++++++++
 tb/tb_display_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/display_decoder_if.sv
// Segment readback bus between the display_decoder and whatever consumes its result.
//   SegIn      segment lines {P,G,F,E,D,C,B,A}, bit0 = A. Asynchronous to the decoder clock.
//   ErrClr     synchronous clear of ErrFlag and ErrCount.
//   Code       last valid decoded 3-bit code.
//   CodeValid  high while the current stable pattern is a valid table entry.
//   CodeStrobe one-cycle pulse on a newly accepted code that differs from the previous one,
//              or on the first accepted code after reset.
//   ErrFlag    sticky indication that an invalid stable pattern was seen.
//   ErrCount   saturating count of invalid stable patterns.
// The master modport drives the segment lines and reads the results; the slave modport is the
// decoder itself.
interface display_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  logic [7:0]       SegIn;
  logic             ErrClr;
  logic [2:0]       Code;
  logic             CodeValid;
  logic             CodeStrobe;
  logic             ErrFlag;
  logic [ERR_W-1:0] ErrCount;

  modport master (
    output SegIn,
    output ErrClr,
    input  Code,
    input  CodeValid,
    input  CodeStrobe,
    input  ErrFlag,
    input  ErrCount
  );

  modport slave (
    input  SegIn,
    input  ErrClr,
    output Code,
    output CodeValid,
    output CodeStrobe,
    output ErrFlag,
    output ErrCount
  );
endinterface

// File: rtl/display_decoder.sv
// Segment display readback decoder.
// Samples the asynchronous 8-line segment bus through a 2-flop synchronizer, waits until the
// pattern (with the F segment masked off) has been identical for STABLE_CYCLES consecutive
// samples, then maps it back to the 3-bit code that produced it or flags it as invalid.
// Ports:
//   Clock   rising-edge clock.
//   NReset  asynchronous active-low reset.
//   bus     display_decoder_if slave modport (SegIn/ErrClr in; Code, CodeValid, CodeStrobe,
//           ErrFlag, ErrCount out). All outputs are registered.
module display_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,  // 1..255
  parameter int unsigned ERR_W         = 8
) (
  input  logic               Clock,
  input  logic               NReset,
  display_decoder_if.slave   bus
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);
  localparam logic [7:0] SegMask   = 8'hDF;  // F segment ignored

  typedef enum logic [0:0] {StSettle, StLocked} state_e;

  // Returns {valid, code}.
  function automatic logic [3:0] decode(input logic [7:0] pat);
    logic [3:0] res;
    case (pat)
      8'h00:   res = 4'b1_000;
      8'h92:   res = 4'b1_001;
      8'hC6:   res = 4'b1_010;
      8'hC0:   res = 4'b1_011;
      8'h88:   res = 4'b1_100;
      8'h83:   res = 4'b1_101;
      8'hC7:   res = 4'b1_110;
      8'h80:   res = 4'b1_111;
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

  logic [7:0]       sync1_q, sync2_q;
  logic [1:0]       fill_q;  // bit1 set once sync2_q holds a real sample rather than reset value
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       ref_q, ref_d;  // previous sample while settling, locked pattern when locked
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             accepted_q, accepted_d;

  logic [7:0]       sample;
  logic             diff;
  logic [3:0]       dec;
  logic [ERR_W-1:0] err_base;

  assign sample = sync2_q & SegMask;
  // A zero count means no reference sample yet, so the first real sample always restarts.
  assign diff   = (sample != ref_q) || (cnt_q == 8'd0);
  assign dec    = decode(sample);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    code_d     = code_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    accepted_d = accepted_q;
    err_base   = bus.ErrClr ? '0 : err_cnt_q;
    err_flag_d = bus.ErrClr ? 1'b0 : err_flag_q;
    err_cnt_d  = err_base;

    if (fill_q[1] && !(state_q == StLocked && !diff)) begin
      ref_d   = sample;
      cnt_d   = diff ? 8'd1 : cnt_q + 8'd1;
      state_d = StSettle;
      valid_d = 1'b0;
      if (cnt_d == StableCnt) begin
        state_d = StLocked;
        if (dec[3]) begin
          code_d     = dec[2:0];
          valid_d    = 1'b1;
          // code_q always holds the last accepted valid code, errors never touch it.
          strobe_d   = !accepted_q || (dec[2:0] != code_q);
          accepted_d = 1'b1;
        end else begin
          // A coincident ErrClr loses to the new error.
          err_flag_d = 1'b1;
          err_cnt_d  = (err_base == '1) ? err_base : err_base + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      fill_q     <= '0;
      state_q    <= StSettle;
      cnt_q      <= '0;
      ref_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      accepted_q <= 1'b0;
    end else begin
      sync1_q    <= bus.SegIn;
      sync2_q    <= sync1_q;
      fill_q     <= {fill_q[0], 1'b1};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      accepted_q <= accepted_d;
    end
  end

  assign bus.Code       = code_q;
  assign bus.CodeValid  = valid_q;
  assign bus.CodeStrobe = strobe_q;
  assign bus.ErrFlag    = err_flag_q;
  assign bus.ErrCount   = err_cnt_q;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder (STABLE_CYCLES=4, ERR_W=2).
module tb_display_decoder;

  logic Clock;
  logic NReset;
  int   errors;
  int   checks;

  display_decoder_if #(.ERR_W(2)) bus ();

  display_decoder #(
    .STABLE_CYCLES(4),
    .ERR_W        (2)
  ) dut (
    .Clock (Clock),
    .NReset(NReset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    NReset     = 1'b0;
    bus.SegIn  = 8'h00;
    bus.ErrClr = 1'b0;
    repeat (3) step();
    checks++; if (bus.Code !== 3'b000) begin errors++;
      $display("FAIL reset_code got=%b want=000", bus.Code); end
    checks++; if (bus.CodeValid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b want=0", bus.CodeValid); end
    checks++; if (bus.CodeStrobe !== 1'b0) begin errors++;
      $display("FAIL reset_strobe got=%b want=0", bus.CodeStrobe); end
    checks++; if (bus.ErrFlag !== 1'b0) begin errors++;
      $display("FAIL reset_errflag got=%b want=0", bus.ErrFlag); end
    checks++; if (bus.ErrCount !== 2'd0) begin errors++;
      $display("FAIL reset_errcount got=%0d want=0", bus.ErrCount); end
  endtask

  // SegIn=0x00 through release: single strobe on the 6th edge after release.
  task automatic test_power_on();
    logic [7:0] strobe_at;
    int nstrobe;
    strobe_at = '0;
    nstrobe   = 0;
    NReset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (bus.CodeStrobe === 1'b1) begin nstrobe++; strobe_at = 8'(e); end
    end
    checks++; if (nstrobe !== 1 || strobe_at !== 8'd6) begin errors++;
      $display("FAIL power_on_strobe got=%0d strobes last_edge=%0d want=1 at edge 6",
               nstrobe, strobe_at); end
    checks++; if (bus.Code !== 3'b000 || bus.CodeValid !== 1'b1) begin errors++;
      $display("FAIL power_on_code got=%b/%b want=000/1", bus.Code, bus.CodeValid); end
  endtask

  // Walk the valid table; strobe exactly 6 edges after each change, CodeValid falls at edge 3.
  task automatic test_sequence();
    logic [7:0] pats [7];
    int total;
    pats = '{8'h92, 8'hC6, 8'hC0, 8'h88, 8'h83, 8'hC7, 8'h80};
    total = 0;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] want;
      int bad;
      want = 3'(k + 1);
      bad  = 0;
      bus.SegIn = pats[k];
      for (int e = 1; e <= 10; e++) begin
        step();
        if (bus.CodeStrobe === 1'b1) total++;
        if ((e == 6) !== (bus.CodeStrobe === 1'b1)) bad++;
        if (e == 2 && bus.CodeValid !== 1'b1) bad++;
        if (e == 3 && bus.CodeValid !== 1'b0) bad++;
        if (e == 6 && bus.Code !== want) bad++;
      end
      checks++; if (bad != 0 || bus.Code !== want || bus.CodeValid !== 1'b1) begin errors++;
        $display("FAIL seq_%02h got code=%b valid=%b timing_errs=%0d want code=%b valid=1",
                 pats[k], bus.Code, bus.CodeValid, bad, want); end
    end
    checks++; if (total != 7) begin errors++;
      $display("FAIL seq_strobe_total got=%0d want=7", total); end
  endtask

  // 2-cycle glitch to 0xC6 on a held 0x92: valid drops and returns, no strobe, no error.
  task automatic test_glitch();
    int nstrobe;
    logic saw_low;
    bus.SegIn = 8'h92;
    repeat (10) step();
    nstrobe = 0;
    saw_low = 1'b0;
    bus.SegIn = 8'hC6;
    repeat (2) begin
      step();
      if (bus.CodeStrobe === 1'b1) nstrobe++;
      if (bus.CodeValid === 1'b0) saw_low = 1'b1;
    end
    bus.SegIn = 8'h92;
    repeat (12) begin
      step();
      if (bus.CodeStrobe === 1'b1) nstrobe++;
      if (bus.CodeValid === 1'b0) saw_low = 1'b1;
    end
    checks++; if (saw_low !== 1'b1) begin errors++;
      $display("FAIL glitch_valid_drop got=no drop want=drop"); end
    checks++; if (nstrobe != 0) begin errors++;
      $display("FAIL glitch_strobe got=%0d want=0", nstrobe); end
    checks++; if (bus.Code !== 3'b001 || bus.CodeValid !== 1'b1 || bus.ErrCount !== 2'd0)
      begin errors++;
      $display("FAIL glitch_final got=%b/%b/%0d want=001/1/0",
               bus.Code, bus.CodeValid, bus.ErrCount); end
  endtask

  // Invalid 0xFF after Code=101, then back to 0x83 without a strobe.
  task automatic test_invalid();
    int nstrobe;
    bus.SegIn = 8'h83;
    repeat (10) step();
    nstrobe = 0;
    bus.SegIn = 8'hFF;
    repeat (20) begin step(); if (bus.CodeStrobe === 1'b1) nstrobe++; end
    checks++; if (bus.ErrFlag !== 1'b1 || bus.ErrCount !== 2'd1) begin errors++;
      $display("FAIL invalid_err got=%b/%0d want=1/1", bus.ErrFlag, bus.ErrCount); end
    checks++; if (bus.CodeValid !== 1'b0 || bus.Code !== 3'b101) begin errors++;
      $display("FAIL invalid_code got=%b/%b want=0/101", bus.CodeValid, bus.Code); end
    bus.SegIn = 8'h83;
    repeat (10) begin step(); if (bus.CodeStrobe === 1'b1) nstrobe++; end
    checks++; if (bus.CodeValid !== 1'b1 || bus.Code !== 3'b101 || nstrobe != 0) begin
      errors++;
      $display("FAIL invalid_return got=%b/%b strobes=%0d want=1/101 strobes=0",
               bus.CodeValid, bus.Code, nstrobe); end
    checks++; if (bus.ErrCount !== 2'd1) begin errors++;
      $display("FAIL invalid_held_once got=%0d want=1", bus.ErrCount); end
  endtask

  // F segment toggling is invisible.
  task automatic test_fmask();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.SegIn = (i % 2 == 0) ? 8'hA3 : 8'h83;
      step();
      if (bus.CodeValid !== 1'b1 || bus.Code !== 3'b101 || bus.CodeStrobe !== 1'b0) bad++;
    end
    bus.SegIn = 8'h83;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL fmask got=%0d bad cycles want=0", bad); end
  endtask

  task automatic test_errclr();
    bus.ErrClr = 1'b1;
    step();
    bus.ErrClr = 1'b0;
    checks++; if (bus.ErrFlag !== 1'b0 || bus.ErrCount !== 2'd0) begin errors++;
      $display("FAIL errclr got=%b/%0d want=0/0", bus.ErrFlag, bus.ErrCount); end
  endtask

  // Saturation at 3, ErrClr coinciding with an evaluation, then reset mid-settle.
  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] want;
      want = (k >= 2) ? 2'd3 : 2'(k + 1);
      bus.SegIn = (k % 2 == 0) ? 8'hFF : 8'h01;
      repeat (8) step();
      checks++; if (bus.ErrCount !== want || bus.ErrFlag !== 1'b1) begin errors++;
        $display("FAIL saturate_%0d got=%0d/%b want=%0d/1", k, bus.ErrCount, bus.ErrFlag, want);
      end
    end
    bus.SegIn = 8'h80;
    repeat (8) step();
    bus.SegIn = 8'hFF;
    repeat (5) step();
    checks++; if (bus.ErrCount !== 2'd3) begin errors++;
      $display("FAIL clr_pre got=%0d want=3", bus.ErrCount); end
    bus.ErrClr = 1'b1;
    step();
    bus.ErrClr = 1'b0;
    checks++; if (bus.ErrCount !== 2'd1 || bus.ErrFlag !== 1'b1) begin errors++;
      $display("FAIL clr_vs_error got=%0d/%b want=1/1", bus.ErrCount, bus.ErrFlag); end
    step();
    checks++; if (bus.ErrCount !== 2'd1) begin errors++;
      $display("FAIL clr_held got=%0d want=1", bus.ErrCount); end
    bus.SegIn = 8'h92;
    repeat (3) step();
    NReset = 1'b0;
    #1;
    checks++; if (bus.Code !== 3'b000 || bus.CodeValid !== 1'b0 || bus.CodeStrobe !== 1'b0)
      begin errors++;
      $display("FAIL midreset_code got=%b/%b/%b want=000/0/0",
               bus.Code, bus.CodeValid, bus.CodeStrobe); end
    checks++; if (bus.ErrFlag !== 1'b0 || bus.ErrCount !== 2'd0) begin errors++;
      $display("FAIL midreset_err got=%b/%0d want=0/0", bus.ErrFlag, bus.ErrCount); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_power_on();
    test_sequence();
    test_glitch();
    test_invalid();
    test_fmask();
    test_errclr();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
